// File: rtl/bram_pkg.sv
// Shared definitions for the dual-port byte-lane block RAM.
//   LANE_W    : width of one byte lane (one bram_lane instance per lane)
//   RDW_*     : same-address read-during-write modes
//   state_e   : top-level FSM states (zero-fill after reset, then normal run)
package bram_pkg;

    localparam int LANE_W = 8;

    localparam bit RDW_OLD_DATA = 1'b0;
    localparam bit RDW_NEW_DATA = 1'b1;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/bram_lane.sv
// One byte lane: simple dual-port, DEPTH x 8 memory with registered read.
// The array has no reset so it maps onto block RAM. With INIT_ZERO=1 the
// array carries a zero power-up value instead.
//   clk            : clock
//   we/waddr/wdata : write port
//   re/raddr       : read port; rdata updates only on a read and holds otherwise
//   rdata          : registered read data (old data on same-address write)
module bram_lane
    import bram_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter bit INIT_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LANE_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [LANE_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (INIT_ZERO) begin : g_init
        logic [LANE_W-1:0] mem [DEPTH] = '{default: '0};
        logic [LANE_W-1:0] rdata_q;

        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
            if (re) rdata_q <= mem[raddr];
        end

        assign rdata = rdata_q;
    end else begin : g_noinit
        logic [LANE_W-1:0] mem [DEPTH];
        logic [LANE_W-1:0] rdata_q;

        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
            if (re) rdata_q <= mem[raddr];
        end

        assign rdata = rdata_q;
    end

endmodule

// File: rtl/bram_dp.sv
// Dual-port block RAM with byte-lane write enables, optional output register,
// selectable read-during-write behaviour and zero-fill after reset.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   rd_en, rd_addr              : read request
//   rd_data, rd_valid           : read result (held) and one-cycle valid pulse
//   wr_en, wr_addr, wr_data, wr_be : write request with per-byte enables
//   ready                       : requests are accepted only while high
module bram_dp
    import bram_pkg::*;
#(
    parameter int DATA_W         = 24,
    parameter int ADDR_W         = 10,
    parameter bit OUT_REG        = 1'b0,
    parameter bit RDW_NEW        = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/LANE_W-1:0]   wr_be,
    output logic                       ready
);

    localparam int LANES = DATA_W / LANE_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                ready_q, ready_d;
    logic                clearing;
    logic                rd_acc;

    logic [LANES-1:0]    lane_we;
    logic [ADDR_W-1:0]   lane_waddr;
    logic [DATA_W-1:0]   lane_wdata;
    logic [DATA_W-1:0]   lane_rdata;

    // Lanes to override with the write data that raced the captured read.
    logic [LANES-1:0]    byp_q, byp_d;
    logic [DATA_W-1:0]   byp_data_q, byp_data_d;
    logic [DATA_W-1:0]   merged;

    logic                v1_q, v1_d;
    logic                v2_q, v2_d;
    // Masks the un-reset lane read registers until the first read after reset.
    logic                has_q, has_d;
    logic [DATA_W-1:0]   out_q, out_d;

    // FSM: walk every address writing zero, then run.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clearing   = 1'b0;
        case (state_q)
            CLEAR: begin
                clearing   = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = RUN;
        endcase
        ready_d = (state_d == RUN);
    end

    assign rd_acc = ready_q & rd_en;

    // Write mux: clear engine owns the write port while clearing.
    always_comb begin
        lane_waddr = clearing ? clr_addr_q : wr_addr;
        lane_wdata = clearing ? '0 : wr_data;
        for (int k = 0; k < LANES; k++) begin
            lane_we[k] = clearing | (ready_q & wr_en & wr_be[k]);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        bram_lane #(
            .ADDR_W    (ADDR_W),
            .INIT_ZERO (!CLEAR_ON_RESET)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we[k]),
            .waddr (lane_waddr),
            .wdata (lane_wdata[k*LANE_W +: LANE_W]),
            .re    (rd_acc),
            .raddr (rd_addr),
            .rdata (lane_rdata[k*LANE_W +: LANE_W])
        );
    end

    // Lanes return old data on a same-address collision; new-data mode patches
    // the written lanes in after the read register.
    always_comb begin
        byp_d      = byp_q;
        byp_data_d = byp_data_q;
        if (rd_acc) begin
            byp_d      = (RDW_NEW == RDW_NEW_DATA && wr_en && rd_addr == wr_addr) ? wr_be : '0;
            byp_data_d = wr_data;
        end
        for (int k = 0; k < LANES; k++) begin
            merged[k*LANE_W +: LANE_W] = byp_q[k] ? byp_data_q[k*LANE_W +: LANE_W]
                                                  : lane_rdata[k*LANE_W +: LANE_W];
        end
    end

    // Output pipeline.
    always_comb begin
        v1_d  = rd_acc;
        v2_d  = v1_q;
        has_d = has_q | rd_acc;
        out_d = v1_q ? merged : out_q;
        if (OUT_REG) begin
            rd_data  = out_q;
            rd_valid = v2_q;
        end else begin
            rd_data  = has_q ? merged : '0;
            rd_valid = v1_q;
        end
    end

    assign ready = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
            byp_q      <= '0;
            byp_data_q <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            has_q      <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            has_q      <= has_d;
            out_q      <= out_d;
        end
    end

endmodule

// File: tb/tb_bram_dp.sv
// Directed bench: dut0 = no output register / old-data RDW,
// dut1 = output register / new-data RDW. Both share the stimulus.
module tb_bram_dp;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [23:0] wr_data;
    logic [2:0]  wr_be;

    logic [23:0] d0, d1;
    logic        v0, v1, r0, r1;

    int nvec = 0;
    int nerr = 0;

    bram_dp #(.DATA_W(24), .ADDR_W(4), .OUT_REG(1'b0), .RDW_NEW(1'b0), .CLEAR_ON_RESET(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d0), .rd_valid(v0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .ready(r0));

    bram_dp #(.DATA_W(24), .ADDR_W(4), .OUT_REG(1'b1), .RDW_NEW(1'b1), .CLEAR_ON_RESET(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .ready(r1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_d(input string tag, input logic [23:0] got, input logic [23:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic got, input logic exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [23:0] d, input logic [2:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        wr_en = 1'b0; wr_be = 3'b000;
    endtask

    // Single read: dut0 answers one cycle after rd_en, dut1 two cycles after.
    task automatic rd2(input string tag, input logic [3:0] a, input logic [23:0] e0, input logic [23:0] e1);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
        chk_b({tag, "_v0_lat1"}, v0, 1'b1);
        chk_d({tag, "_d0"}, d0, e0);
        chk_b({tag, "_v1_lat1"}, v1, 1'b0);
        step();
        chk_b({tag, "_v0_lat2"}, v0, 1'b0);
        chk_b({tag, "_v1_lat2"}, v1, 1'b1);
        chk_d({tag, "_d1"}, d1, e1);
    endtask

    // Hold reset for one edge, release, then expect ready after exactly 16 edges.
    task automatic clear_check(input string tag, input bit poke);
        for (int i = 1; i <= 16; i++) begin
            if (poke && i == 7) begin
                // Address 3 was already cleared; this write must be dropped.
                wr_en = 1'b1; wr_addr = 4'd3; wr_data = 24'h777777; wr_be = 3'b111;
                rd_en = 1'b1; rd_addr = 4'd3;
            end
            step();
            wr_en = 1'b0; rd_en = 1'b0; wr_be = 3'b000;
            chk_b({tag, "_nv0"}, v0, 1'b0);
            chk_b({tag, "_nv1"}, v1, 1'b0);
            if (i == 15) begin
                chk_b({tag, "_rdy0_15"}, r0, 1'b0);
                chk_b({tag, "_rdy1_15"}, r1, 1'b0);
            end
            if (i == 16) begin
                chk_b({tag, "_rdy0_16"}, r0, 1'b1);
                chk_b({tag, "_rdy1_16"}, r1, 1'b1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; rd_en = 1'b0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;

        // Reset state
        #1;
        chk_d("rst_d0", d0, 24'h0);  chk_d("rst_d1", d1, 24'h0);
        chk_b("rst_v0", v0, 1'b0);   chk_b("rst_v1", v1, 1'b0);
        chk_b("rst_r0", r0, 1'b0);   chk_b("rst_r1", r1, 1'b0);
        step();
        rst_n = 1'b1;
        clear_check("clr", 1'b0);

        // Every address reads zero after the fill
        for (int a = 0; a < 16; a++) rd2("clr_rd", 4'(a), 24'h0, 24'h0);

        // Byte enables
        wr(4'd5, 24'hAABBCC, 3'b111);
        wr(4'd5, 24'h112233, 3'b010);
        rd2("be", 4'd5, 24'hAA22CC, 24'hAA22CC);

        // Back-to-back reads 5, 6, 5
        wr(4'd6, 24'h123456, 3'b111);
        rd_en = 1'b1; rd_addr = 4'd5;
        step();
        chk_b("b2b_a_v0", v0, 1'b1); chk_d("b2b_a_d0", d0, 24'hAA22CC); chk_b("b2b_a_v1", v1, 1'b0);
        rd_addr = 4'd6;
        step();
        chk_b("b2b_b_v0", v0, 1'b1); chk_d("b2b_b_d0", d0, 24'h123456);
        chk_b("b2b_b_v1", v1, 1'b1); chk_d("b2b_b_d1", d1, 24'hAA22CC);
        rd_addr = 4'd5;
        step();
        chk_b("b2b_c_v0", v0, 1'b1); chk_d("b2b_c_d0", d0, 24'hAA22CC);
        chk_b("b2b_c_v1", v1, 1'b1); chk_d("b2b_c_d1", d1, 24'h123456);
        rd_en = 1'b0;
        step();
        chk_b("b2b_d_v0", v0, 1'b0); chk_d("b2b_d_hold0", d0, 24'hAA22CC);
        chk_b("b2b_d_v1", v1, 1'b1); chk_d("b2b_d_d1", d1, 24'hAA22CC);
        step();
        chk_b("b2b_e_v1", v1, 1'b0); chk_d("b2b_e_hold1", d1, 24'hAA22CC);

        // Read-during-write, full word
        wr(4'd7, 24'h000001, 3'b111);
        rd_en = 1'b1; rd_addr = 4'd7;
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 24'h0000FF; wr_be = 3'b111;
        step();
        rd_en = 1'b0; wr_en = 1'b0; wr_be = 3'b000;
        chk_d("rdw_old_d0", d0, 24'h000001);
        step();
        chk_d("rdw_new_d1", d1, 24'h0000FF);

        // Read-during-write, one lane
        rd_en = 1'b1; rd_addr = 4'd7;
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 24'h00AB00; wr_be = 3'b010;
        step();
        rd_en = 1'b0; wr_en = 1'b0; wr_be = 3'b000;
        chk_d("rdwp_old_d0", d0, 24'h0000FF);
        step();
        chk_d("rdwp_new_d1", d1, 24'h00ABFF);

        // wr_be=0 changes nothing
        wr(4'd7, 24'hFFFFFF, 3'b000);
        rd2("be0", 4'd7, 24'h00ABFF, 24'h00ABFF);

        // Read and write to different addresses together
        rd_en = 1'b1; rd_addr = 4'd5;
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 24'h555555; wr_be = 3'b111;
        step();
        rd_en = 1'b0; wr_en = 1'b0; wr_be = 3'b000;
        chk_d("diff_d0", d0, 24'hAA22CC);
        step();
        chk_d("diff_d1", d1, 24'hAA22CC);
        rd2("diff_rd9", 4'd9, 24'h555555, 24'h555555);

        // Reset while dut1 has a read in its output stage
        rd_en = 1'b1; rd_addr = 4'd5;
        step();
        rd_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_d("rstrun_d0", d0, 24'h0); chk_d("rstrun_d1", d1, 24'h0);
        chk_b("rstrun_v0", v0, 1'b0);  chk_b("rstrun_v1", v1, 1'b0);
        chk_b("rstrun_r0", r0, 1'b0);  chk_b("rstrun_r1", r1, 1'b0);
        step();
        chk_b("rstrun_drop_v1", v1, 1'b0);
        rst_n = 1'b1;

        // Reset mid-clear at address 8, then a dropped write during the refill
        for (int i = 0; i < 8; i++) step();
        chk_b("mid_r0", r0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        clear_check("mid", 1'b1);
        rd2("mid_rd3", 4'd3, 24'h0, 24'h0);
        rd2("mid_rd5", 4'd5, 24'h0, 24'h0);
        rd2("mid_rd9", 4'd9, 24'h0, 24'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bram_dp.md
BRAM_DP -- requirements
Module: bram_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 24, giving the data width; it is a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 10, giving the address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter OUT_REG, default 0; 1 adds an output register stage.
REQ-004 SHALL have parameter RDW_NEW, default 0, selecting same-address read-during-write mode: 0 = old data, 1 = new data.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1; 1 zero-fills memory after reset.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  clock; all state on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 rd_en  input  1  read request.
REQ-010 rd_addr  input  ADDR_W  read address.
REQ-011 rd_data  output  DATA_W  read data; holds its value between reads.
REQ-012 rd_valid  output  1  single-cycle pulse marking new rd_data.
REQ-013 wr_en  input  1  write request.
REQ-014 wr_addr  input  ADDR_W  write address.
REQ-015 wr_data  input  DATA_W  write data.
REQ-016 wr_be  input  DATA_W/8  byte-lane write enables; bit k covers wr_data[8k+7:8k].
REQ-017 ready  output  1  high when the memory accepts requests.

Function
REQ-018 SHALL implement an FSM with states CLEAR and RUN; it enters CLEAR on reset if CLEAR_ON_RESET=1, else RUN.
REQ-019 CLEAR SHALL write zero to all lanes at an internal counter address, from 0 up to DEPTH-1, one address per cycle, with ready=0.
REQ-020 After the DEPTH-1 write, the FSM SHALL enter RUN on the next edge; ready=1 from that edge onward, so clear takes exactly DEPTH cycles after reset release.
REQ-021 While ready=0, rd_en and wr_en SHALL be ignored: no write, no rd_valid.
REQ-022 In RUN, wr_en=1 SHALL update only lanes whose wr_be bit is 1; wr_en=1 with wr_be=0 SHALL leave memory unchanged.
REQ-023 In RUN, rd_en=1 at edge N SHALL give rd_data and rd_valid=1 after edge N+1 (OUT_REG=0) or after edge N+2 (OUT_REG=1).
REQ-024 Back-to-back reads SHALL be accepted every cycle, giving one rd_valid per read in order.
REQ-025 When rd_addr==wr_addr in the same cycle, RDW_NEW=0 SHALL return pre-write data; RDW_NEW=1 SHALL return the old word with the written lanes replaced by wr_data.
REQ-026 Simultaneous read and write to different addresses SHALL both complete with no interaction.
REQ-027 Addresses SHALL be full-range; no wrap or out-of-range case exists.
REQ-028 When CLEAR_ON_RESET=0, memory contents SHALL be initialised to zero at configuration, and no reset clear SHALL occur.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately set rd_data=0, rd_valid=0, ready=0, and drop pending OUT_REG stages.
REQ-030 Reset asserted during CLEAR SHALL restart the clear from address 0 after release.
REQ-031 Memory array contents SHALL NOT be reset directly; they are cleared only by the CLEAR state, so block RAM inference is preserved.

Structure
REQ-032 Package bram_pkg SHALL hold LANE_W=8, the FSM state type (CLEAR, RUN), and the RDW mode constants.
REQ-033 The block SHALL instantiate DATA_W/8 copies of the sub-module bram_lane: an 8-bit-wide, DEPTH-deep simple dual-port memory with a registered read and no reset on its array.
REQ-034 The FSM, clear counter, write muxing, RDW bypass and output pipeline SHALL reside in bram_dp.

Verification
REQ-035 Clear: release reset with ADDR_W=4 -> ready rises exactly 16 cycles later; reads of addresses 0..15 all return 0x000000.
REQ-036 Byte enables: write 0xAABBCC to address 5 with wr_be=111, then 0x112233 with wr_be=010 -> a read of address 5 returns 0xAA22CC.
REQ-037 Latency: OUT_REG=0 and OUT_REG=1, read address 5 -> rd_valid appears 1 or 2 cycles after rd_en respectively; back-to-back reads of addresses 5, 6, 5 give three in-order pulses.
REQ-038 RDW: address 7 holds 0x000001; read and write 0x0000FF (wr_be=111) to address 7 in the same cycle -> RDW_NEW=0 returns 0x000001, RDW_NEW=1 returns 0x0000FF.
REQ-039 Reset mid-clear: assert rst_n at clear address 8, release -> ready rises DEPTH cycles after release; a write issued while ready=0 has no effect.
